axis_frame_fifo: RTL

AXIS_FRAME_FIFO -- requirements
Module: axis_frame_fifo

---
 rtl/axis_frame_fifo_if.sv | 19 +
 rtl/axis_frame_fifo.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/axis_frame_fifo_if.sv
// axis_frame_fifo_if
//   AXI4-Stream style beat interface carrying data, valid, ready and last.
//   Handshake: a beat transfers on a rising edge where tvalid && tready are
//   both 1. While tvalid is 1 and tready is 0, the master holds tdata,
//   tlast and tvalid unchanged.
//   Modports:
//     master : drives tdata/tvalid/tlast, samples tready
//     slave  : samples tdata/tvalid/tlast, drives tready
interface axis_frame_fifo_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_frame_fifo.sv
// axis_frame_fifo
//   Word FIFO fed by register-block pushes, drained as an AXI4-Stream with
//   tlast framing every frame_len beats. The stream head sits in a
//   registered output stage, so a word pushed into an empty FIFO appears on
//   the stream one cycle after it is written.
//   Ports:
//     ACLK, ARESET   : clock, asynchronous active-high reset
//     push_valid/push_data/push_ready : write side; a push is accepted
//                      on an edge where push_valid && push_ready
//     frame_len      : beats per frame, sampled at the first beat of a frame
//     clear          : synchronous flush of data, framing and overflow
//     m_axis         : stream output (master modport)
//     fill_count     : words held, output register included
//     overflow       : sticky flag, set when a push hits a full FIFO
//     dbg_in_frame   : frame FSM state (1 = IN_FRAME)
module axis_frame_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int LEN_WIDTH  = 16,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  push_valid,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  push_ready,
  input  logic [LEN_WIDTH-1:0]  frame_len,
  input  logic                  clear,
  axis_frame_fifo_if.master     m_axis,
  output logic [AW:0]           fill_count,
  output logic                  overflow,
  output logic                  dbg_in_frame
);

  typedef enum logic {IDLE = 1'b0, IN_FRAME = 1'b1} state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           mem_count;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  rdy_en;
  logic                  full;
  logic                  push_acc;
  logic                  beat;
  logic                  load;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  beat_cnt, beat_cnt_d;
  logic [LEN_WIDTH-1:0]  eff_len;
  logic                  last;

  // fill_count counts the output register as one entry.
  assign fill_count = mem_count + {{AW{1'b0}}, out_valid};
  assign full       = (fill_count == (AW+1)'(DEPTH));
  // rdy_en keeps push_ready low until the first edge after reset release.
  assign push_ready = rdy_en && !full;
  assign push_acc   = push_valid && push_ready && !clear;
  assign beat       = out_valid && m_axis.tready;
  // Refill the output register whenever it is empty or being consumed.
  assign load       = (mem_count != '0) && (!out_valid || m_axis.tready);

  assign m_axis.tdata  = out_data;
  assign m_axis.tvalid = out_valid;
  assign m_axis.tlast  = last;
  assign dbg_in_frame  = (state_q == IN_FRAME);

  always_ff @(posedge ACLK) begin
    if (push_acc) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rdy_en    <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (clear) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        mem_count <= '0;
        out_data  <= '0;
        out_valid <= 1'b0;
        overflow  <= 1'b0;
      end else begin
        if (push_acc) wr_ptr <= wr_ptr + AW'(1);
        // A push against a full FIFO is dropped even if a pop frees space
        // on the same edge.
        if (push_valid && full) overflow <= 1'b1;
        if (load) begin
          rd_ptr    <= rd_ptr + AW'(1);
          out_data  <= mem[rd_ptr];
          out_valid <= 1'b1;
        end else if (beat) begin
          out_valid <= 1'b0;
        end
        mem_count <= mem_count + (AW+1)'(push_acc) - (AW+1)'(load);
      end
    end
  end

  // Frame FSM: in IDLE the live frame_len (0 treated as 1) governs the first
  // beat; once a frame has started, the latched len_q is used so later
  // frame_len changes do not disturb the current frame.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt;
    if (state_q == IDLE)
      eff_len = (frame_len == '0) ? LEN_WIDTH'(1) : frame_len;
    else
      eff_len = len_q;
    last = out_valid && (beat_cnt == eff_len - LEN_WIDTH'(1));
    if (beat) begin
      if (state_q == IDLE) len_d = eff_len;
      if (last) begin
        state_d    = IDLE;
        beat_cnt_d = '0;
      end else begin
        state_d    = IN_FRAME;
        beat_cnt_d = beat_cnt + LEN_WIDTH'(1);
      end
    end
    if (clear) begin
      state_d    = IDLE;
      beat_cnt_d = '0;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q  <= IDLE;
      len_q    <= LEN_WIDTH'(1);
      beat_cnt <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      beat_cnt <= beat_cnt_d;
    end
  end

endmodule
